// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sequencer slice.
//   - ALU op-select codes, as driven on alu_sel / cmd_sel.
//   - FSM state encoding for alu_seq_driver.
//   - Width of the settle counter, which covers SETTLE_CYCLES 1..15.
// ----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_XOR = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b11;

  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/alu_ref_model.sv
// ----------------------------------------------------------------------------
// alu_ref_model
// Purely combinational golden model of the ALU, used by alu_seq_driver to
// check each captured result.
// Ports:
//   a, b       in  WIDTH  operands
//   sel        in  2      op select (AND/OR/XOR/ADD)
//   exp_out    out WIDTH  expected result
//   exp_carry  out 1      expected carry (only ADD can produce a carry)
//   exp_zero   out 1      expected zero flag (exp_out == 0)
// ----------------------------------------------------------------------------
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] exp_out,
  output logic             exp_carry,
  output logic             exp_zero
);

  // One extra bit so the ADD carry falls out of the sum directly.
  logic [WIDTH:0] sum;
  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    exp_out   = a & b;
    exp_carry = 1'b0;
    case (sel)
      ALU_AND: exp_out = a & b;
      ALU_OR:  exp_out = a | b;
      ALU_XOR: exp_out = a ^ b;
      ALU_ADD: {exp_carry, exp_out} = sum;
      default: exp_out = a & b;
    endcase
    exp_zero = (exp_out == '0);
  end

endmodule

// File: rtl/alu_seq_driver.sv
// ----------------------------------------------------------------------------
// alu_seq_driver
// Sequential initiator for a combinational ALU. A command (a, b, sel) is
// accepted over valid/ready, registered onto alu_*, held for SETTLE_CYCLES,
// then the ALU outputs are captured and offered on a valid/ready response
// channel. Only one operation is in flight at a time.
//
// Build option: define ALU_SEQ_CHECK_EN to instantiate the reference model;
// rsp_mismatch then flags results that differ from it and err_count counts
// them. Without it both outputs are tied to 0.
//
// Parameters: WIDTH (operand width), SETTLE_CYCLES (1..15), CNT_W (counter
// width).
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_a, cmd_b, cmd_sel             command payload
//   alu_a, alu_b, alu_sel             registered drive into the ALU
//   alu_out, alu_carry, alu_zero      ALU results
//   rsp_valid/rsp_ready               response handshake
//   rsp_out, rsp_carry, rsp_zero      captured ALU results
//   rsp_mismatch                      captured result differs from model
//   op_count, err_count               saturating completion/error counters
// ----------------------------------------------------------------------------
module alu_seq_driver
  import alu_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [1:0]       cmd_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_mismatch,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] err_count
);

  // Counter counts down to 0; the capture happens on the edge where it is 0,
  // so loading SETTLE_CYCLES-1 gives exactly SETTLE_CYCLES settle edges.
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE     = CNT_W'(1);

  state_e              state_reg, state_next;
  logic [SETTLE_W-1:0] cnt_reg;
  logic [WIDTH-1:0]    alu_a_reg, alu_b_reg, rsp_out_reg;
  logic [1:0]          alu_sel_reg;
  logic                rsp_valid_reg, rsp_carry_reg, rsp_zero_reg;
  logic [CNT_W-1:0]    op_count_reg;
  logic                accept, capture, rsp_done;

  // Next-state and handshake decode. cmd_ready is masked by rst so nothing
  // can be accepted on an edge where reset wins.
  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    rsp_done   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cmd_ready = ~rst;
        if (cmd_valid && cmd_ready) begin
          accept     = 1'b1;
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_valid_reg && rsp_ready) begin
          rsp_done   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_sel_reg   <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_out_reg   <= '0;
      rsp_carry_reg <= 1'b0;
      rsp_zero_reg  <= 1'b0;
      op_count_reg  <= '0;
    end else begin
      if (accept) begin
        alu_a_reg   <= cmd_a;
        alu_b_reg   <= cmd_b;
        alu_sel_reg <= cmd_sel;
        cnt_reg     <= SETTLE_LOAD;
      end
      if (state_reg == ST_SETTLE && cnt_reg != '0)
        cnt_reg <= cnt_reg - SETTLE_W'(1);
      if (capture) begin
        rsp_out_reg   <= alu_out;
        rsp_carry_reg <= alu_carry;
        rsp_zero_reg  <= alu_zero;
        rsp_valid_reg <= 1'b1;
      end
      if (rsp_done) begin
        rsp_valid_reg <= 1'b0;
        if (op_count_reg != '1)
          op_count_reg <= op_count_reg + CNT_ONE;
      end
    end
  end

  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_sel   = alu_sel_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_out   = rsp_out_reg;
  assign rsp_carry = rsp_carry_reg;
  assign rsp_zero  = rsp_zero_reg;
  assign op_count  = op_count_reg;

`ifdef ALU_SEQ_CHECK_EN
  logic [WIDTH-1:0] exp_out;
  logic             exp_carry, exp_zero, mismatch_now, rsp_mismatch_reg;
  logic [CNT_W-1:0] err_count_reg;

  // The model sees the same registered operands as the ALU, so its answer is
  // valid for the whole settle window.
  alu_ref_model #(.WIDTH(WIDTH)) u_ref_model (
    .a         (alu_a_reg),
    .b         (alu_b_reg),
    .sel       (alu_sel_reg),
    .exp_out   (exp_out),
    .exp_carry (exp_carry),
    .exp_zero  (exp_zero)
  );

  assign mismatch_now = (alu_out != exp_out) || (alu_carry != exp_carry) ||
                        (alu_zero != exp_zero);

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_mismatch_reg <= 1'b0;
      err_count_reg    <= '0;
    end else begin
      if (capture)
        rsp_mismatch_reg <= mismatch_now;
      if (rsp_done && rsp_mismatch_reg && err_count_reg != '1)
        err_count_reg <= err_count_reg + CNT_ONE;
    end
  end

  assign rsp_mismatch = rsp_mismatch_reg;
  assign err_count    = err_count_reg;
`else
  assign rsp_mismatch = 1'b0;
  assign err_count    = '0;
`endif

endmodule
